// File: rtl/key_add_flag_gen_if.sv
// Board-key pin and the pulse/level pair handed to the display counter.
// The master side drives the raw key; the slave side is the debouncer.
interface key_add_flag_gen_if;
  logic key;        // raw button, 0 = pressed, asynchronous to clk
  logic add_flag;   // single-cycle increment pulse
  logic key_state;  // debounced level, 1 = pressed

  modport master (
    output key,
    input  add_flag,
    input  key_state
  );

  modport slave (
    input  key,
    output add_flag,
    output key_state
  );
endinterface

// File: rtl/key_add_flag_gen.sv
// Debounces an active-low push-button and emits one add_flag pulse per press,
// with optional auto-repeat while the button stays held.
module key_add_flag_gen #(
  parameter int DEBOUNCE_CNT = 1_000_000,
  parameter int HOLD_CNT     = 50_000_000,
  parameter int REPEAT_CNT   = 10_000_000,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  key_add_flag_gen_if.slave  kif
);

  localparam int MAX_AB  = (DEBOUNCE_CNT > HOLD_CNT) ? DEBOUNCE_CNT : HOLD_CNT;
  localparam int MAX_CNT = (MAX_AB > REPEAT_CNT) ? MAX_AB : REPEAT_CNT;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CNT - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_PRESS_DB   = 3'd1;
  localparam logic [2:0] S_HELD       = 3'd2;
  localparam logic [2:0] S_REPEAT     = 3'd3;
  localparam logic [2:0] S_RELEASE_DB = 3'd4;

  logic             key_meta;
  logic             key_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             add_flag_q, add_flag_d;
  logic             key_state_q, key_state_d;

  // Two-flop synchroniser; both stages reset to the released level so a
  // key held through reset is seen as a fresh press afterwards.
  // NOTE: sequential state always uses non-blocking (<=) so every flop
  // samples the pre-edge value of its neighbours, as real hardware does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 1'b1;
      key_s    <= 1'b1;
    end else begin
      key_meta <= kif.key;
      key_s    <= key_meta;
    end
  end

  // Next-state logic. A key_s change is checked before any terminal count,
  // so a level change coinciding with terminal count never pulses.
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    add_flag_d  = 1'b0;
    key_state_d = key_state_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!key_s) state_d = S_PRESS_DB;
      end

      S_PRESS_DB: begin
        if (key_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d     = S_HELD;
          cnt_d       = '0;
          key_state_d = 1'b1;
          add_flag_d  = 1'b1;
        end
      end

      S_HELD: begin
        if (key_s) begin
          state_d = S_RELEASE_DB;
          cnt_d   = '0;
        end else if (!REPEAT_EN) begin
          cnt_d = '0;  // no repeat timer to run
        end else if (cnt_q == HOLD_LAST) begin
          state_d    = S_REPEAT;
          cnt_d      = '0;
          add_flag_d = 1'b1;
        end
      end

      S_REPEAT: begin
        if (key_s) begin
          state_d = S_RELEASE_DB;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d      = '0;
          add_flag_d = 1'b1;
        end
      end

      S_RELEASE_DB: begin
        // A bounce back to pressed restarts the hold timer from scratch.
        if (!key_s) begin
          state_d = S_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          key_state_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      add_flag_q  <= 1'b0;
      key_state_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_flag_q  <= add_flag_d;
      key_state_q <= key_state_d;
    end
  end

  assign kif.add_flag  = add_flag_q;
  assign kif.key_state = key_state_q;

endmodule

// File: tb/tb_key_add_flag_gen.sv
// Scoreboard bench for key_add_flag_gen: stimulus queues expected pulse and
// key_state edge cycles; negedge monitors pop and compare them.
module tb_key_add_flag_gen;

  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;

  typedef struct {
    int cyc;
    bit val;
  } ks_ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic key   = 1'b1;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  int     pq0[$];
  int     pq1[$];
  ks_ev_t kq0[$];
  ks_ev_t kq1[$];
  logic   ks_prev0 = 1'b0;
  logic   ks_prev1 = 1'b0;

  key_add_flag_gen_if kif0 ();
  key_add_flag_gen_if kif1 ();
  assign kif0.key = key;
  assign kif1.key = key;

  key_add_flag_gen #(
    .DEBOUNCE_CNT (DB),
    .HOLD_CNT     (HOLD),
    .REPEAT_CNT   (REP),
    .REPEAT_EN    (1'b1)
  ) u_dut_rep (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif0)
  );

  key_add_flag_gen #(
    .DEBOUNCE_CNT (DB),
    .HOLD_CNT     (HOLD),
    .REPEAT_CNT   (REP),
    .REPEAT_EN    (1'b0)
  ) u_dut_norep (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_pulse(input int inst, input logic af);
    int exp;
    if (af === 1'b1) begin
      if ((inst == 0 && pq0.size() == 0) || (inst == 1 && pq1.size() == 0)) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse_inst%0d: actual add_flag=1 required=0 (cycle %0d)", inst, cyc);
      end else begin
        if (inst == 0) exp = pq0.pop_front();
        else           exp = pq1.pop_front();
        check($sformatf("pulse_cycle_inst%0d", inst), cyc, exp);
      end
    end
  endtask

  task automatic mon_ks(input int inst, input logic ks);
    ks_ev_t ev;
    if ((inst == 0 && kq0.size() == 0) || (inst == 1 && kq1.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL unexpected_key_state_inst%0d: actual edge to %0d, required no edge (cycle %0d)",
               inst, ks, cyc);
    end else begin
      if (inst == 0) ev = kq0.pop_front();
      else           ev = kq1.pop_front();
      check($sformatf("key_state_edge_cycle_inst%0d", inst), cyc, ev.cyc);
      check($sformatf("key_state_edge_value_inst%0d", inst), {31'd0, ks}, {31'd0, ev.val});
    end
  endtask

  // Monitor: decoupled from stimulus, samples on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      ks_prev0 <= 1'b0;
      ks_prev1 <= 1'b0;
    end else begin
      mon_pulse(0, kif0.add_flag);
      mon_pulse(1, kif1.add_flag);
      if (kif0.key_state !== ks_prev0) mon_ks(0, kif0.key_state);
      if (kif1.key_state !== ks_prev1) mon_ks(1, kif1.key_state);
      ks_prev0 <= kif0.key_state;
      ks_prev1 <= kif1.key_state;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_pulse(input int c, input bit both);
    pq0.push_back(c);
    if (both) pq1.push_back(c);
  endtask

  task automatic exp_ks(input int c, input bit v);
    kq0.push_back('{cyc: c, val: v});
    kq1.push_back('{cyc: c, val: v});
  endtask

  task automatic check_outputs(input string tag, input logic af, input logic ks);
    check({tag, "_add_flag_rep"},    {31'd0, kif0.add_flag},  {31'd0, af});
    check({tag, "_key_state_rep"},   {31'd0, kif0.key_state}, {31'd0, ks});
    check({tag, "_add_flag_norep"},  {31'd0, kif1.add_flag},  {31'd0, af});
    check({tag, "_key_state_norep"}, {31'd0, kif1.key_state}, {31'd0, ks});
  endtask

  // Release the key at the current negedge; key_state falls DB+3 edges later.
  task automatic release_key();
    key = 1'b1;
    exp_ks(cyc + DB + 3, 1'b0);
  endtask

  // Press at the current negedge; first pulse and key_state rise DB+3 edges later.
  task automatic press_key(output int p);
    key = 1'b0;
    p   = cyc + DB + 3;
    exp_pulse(p, 1'b1);
    exp_ks(p, 1'b1);
  endtask

  initial begin
    int p;
    int m;

    // Reset values while rst_n is low.
    rst_n = 1'b0;
    key   = 1'b1;
    step(3);
    #1;
    check_outputs("reset", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle key for 100 cycles: nothing must happen.
    step(100);
    #1;
    check_outputs("idle", 1'b0, 1'b0);
    @(negedge clk);

    // Clean press held 10 cycles.
    press_key(p);
    step(10);
    release_key();
    step(20);

    // Bouncy press: 2 low, 1 high, 3 low, 2 high, then settle low.
    key = 1'b0; step(2);
    key = 1'b1; step(1);
    key = 1'b0; step(3);
    key = 1'b1; step(2);
    press_key(p);
    step(10);
    release_key();
    step(20);

    // Key_s returns high exactly at press terminal count: no pulse.
    key = 1'b0;
    step(4);
    key = 1'b1;
    step(20);

    // Long hold: repeats at +20, +28 .. +60 only with auto-repeat enabled.
    press_key(p);
    for (int o = HOLD; o <= HOLD + 5 * REP; o += REP) exp_pulse(p + o, 1'b0);
    step(p + 62 - cyc);
    release_key();
    step(30);

    // Release glitch during HELD: hold timer restarts when HELD is re-entered.
    press_key(p);
    step(p + 5 - cyc);
    key = 1'b1;
    step(2);
    key = 1'b0;
    exp_pulse(p + 10 + HOLD, 1'b0);
    step(5);
    #1;
    check("glitch_key_state_rep",   {31'd0, kif0.key_state}, 32'd1);
    check("glitch_key_state_norep", {31'd0, kif1.key_state}, 32'd1);
    step(p + 33 - cyc);
    release_key();
    step(30);

    // Reset during PRESS_DB with key held low.
    key = 1'b0;
    step(4);
    rst_n = 1'b0;
    #1;
    check_outputs("rst_press_db", 1'b0, 1'b0);
    step(2);
    rst_n = 1'b1;
    m = cyc;
    exp_pulse(m + DB + 3, 1'b1);
    exp_ks(m + DB + 3, 1'b1);
    step(12);
    release_key();
    step(20);

    // Reset during HELD: key_state must drop at once, then re-debounce.
    press_key(p);
    step(p + 3 - cyc);
    rst_n = 1'b0;
    #1;
    check_outputs("rst_held", 1'b0, 1'b0);
    step(2);
    rst_n = 1'b1;
    m = cyc;
    exp_pulse(m + DB + 3, 1'b1);
    exp_ks(m + DB + 3, 1'b1);
    step(12);
    release_key();
    step(30);

    // Every queued expectation must have been consumed.
    check("pending_pulses_rep",    pq0.size(), 0);
    check("pending_pulses_norep",  pq1.size(), 0);
    check("pending_ks_edges_rep",  kq0.size(), 0);
    check("pending_ks_edges_norep", kq1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_add_flag_gen.md
Name: key_add_flag_gen

Overview:
- Generates the add_flag increment pulse consumed by the static 7-segment display driver.
- Input is one raw, bouncy, active-low push-button. The block synchronises it and debounces press and release.
- Emits exactly one single-cycle add_flag per debounced press. Optional auto-repeat while the button is held.
- Sits between the board key pin and the display counter logic.

Parameters:
- DEBOUNCE_CNT, 1_000_000, stable-level cycles required to accept a press or release (20 ms at 50 MHz).
- HOLD_CNT, 50_000_000, cycles from accepted press to first auto-repeat pulse (1 s).
- REPEAT_CNT, 10_000_000, cycles between subsequent auto-repeat pulses (200 ms).
- REPEAT_EN, 1, 1 enables auto-repeat; 0 gives one pulse per press only.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- key  input  1  raw button, 0 = pressed, asynchronous to clk
- add_flag  output  1  single-cycle increment pulse, registered
- key_state  output  1  debounced level, 1 = pressed, registered

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Asserting rst_n low immediately forces: state=IDLE, counter=0, add_flag=0, key_state=0.
  - Both synchroniser flops reset to 1 (released).
  - Reset mid-press aborts with no pulse. After release of reset, a still-held key must be re-debounced and then yields one pulse.
- Synchroniser: 2-flop chain on key. key_s is the second flop. The FSM uses only key_s.
- Counter: one shared counter, width $clog2 of the largest parameter, cleared on every state change. It never wraps; it is cleared at terminal count.
- add_flag: defaults to 0 every cycle. It is set to 1 only on the transitions marked "pulse" below, so it is never high for two consecutive cycles.
- FSM states and transitions:
  - IDLE: key_s=0 -> PRESS_DB.
  - PRESS_DB: key_s=1 -> IDLE (bounce, no pulse). counter==DEBOUNCE_CNT-1 -> HELD, key_state<=1, pulse.
  - HELD: key_s=1 -> RELEASE_DB. REPEAT_EN=1 and counter==HOLD_CNT-1 -> REPEAT, pulse. With REPEAT_EN=0, HELD stays put and the counter saturates at 0.
  - REPEAT: key_s=1 -> RELEASE_DB. counter==REPEAT_CNT-1 -> pulse, counter<=0, stay in REPEAT.
  - RELEASE_DB: key_s=0 -> HELD (bounce, counter cleared, hold timer restarts, no pulse). counter==DEBOUNCE_CNT-1 -> IDLE, key_state<=0.
- Simultaneous events: when key_s changes in the same cycle the counter hits terminal count, the key_s change wins and no pulse is issued.
- Latency:
  - key sampled low at edge 0 and held stable: add_flag is high for the cycle following edge DEBOUNCE_CNT+3.
  - Repeat pulses follow the first pulse after HOLD_CNT cycles, then every REPEAT_CNT cycles.
  - key_state falls DEBOUNCE_CNT+3 edges after a clean release.

Test Plan (DEBOUNCE_CNT=4, HOLD_CNT=20, REPEAT_CNT=8, REPEAT_EN=1):
- Reset then key=1 constant for 100 cycles -> add_flag=0 and key_state=0 throughout; reset values checked while rst_n low.
- Clean press (key 1->0 at edge 0, held 10 cycles, then released) -> exactly one add_flag pulse, high only after edge 7; key_state rises with it and falls 7 edges after release.
- Bouncy press: key toggles 0/1/0/1 with 1–3-cycle widths, then settles at 0 -> no pulse during bouncing, exactly one pulse 7 edges after final settle.
- Long hold for 60 cycles past the first pulse -> pulses at offsets 0, 20, 28, 36, 44, 52, 60 relative to the first; none after a clean release. With REPEAT_EN=0, only the offset-0 pulse.
- Release glitch: during HELD, key high for 2 cycles then low again -> no pulse, key_state stays 1, next repeat pulse occurs 20 cycles after the glitch ends.
- rst_n pulsed low during PRESS_DB with key held low -> add_flag and key_state 0 immediately; after reset release, one pulse 7 edges after key_s is seen low.
